// File: rtl/rv32_mem_pkg.sv
// Package for the MEM-stage data-memory access unit.
// Contents:
//   mem_state_e  - access sequencer states IDLE/REQ/RESP/DONE
//   mem_op_e     - EX/MEM data_ctrl encoding (2'b11 behaves as OP_NONE)
//   acc_size_e   - access width class derived from funct3
//   F3_*         - funct3 encodings of the load/store widths
//   access_size  - funct3 -> width class (store and load decode differ)
//   is_misaligned- width class + addr[1:0] -> misaligned access flag
package rv32_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mem_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know SB/SH; every other store funct3 is a full word.
  // Loads add the unsigned byte/half forms; the rest read a full word.
  function automatic acc_size_e access_size(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      if (f3 == F3_B) return SZ_B;
      if (f3 == F3_H) return SZ_H;
      return SZ_W;
    end
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] a);
    return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/rv32_mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
// Signals:
//   dmem_req_valid/ready - request handshake
//   dmem_req_we          - 1 store, 0 load
//   dmem_req_addr        - word-aligned address
//   dmem_req_wdata/be    - lane-replicated store data and byte enables
//   dmem_rsp_valid/rdata - load response
interface rv32_mem_access_unit_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/rv32_load_align.sv
// Combinational load alignment: picks the byte/half lane out of the read
// word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata_i   - 32-bit word returned by memory
//   addr_lo_i - addr[1:0]; byte lane = addr[1:0], half lane = addr[1]
//   funct3_i  - load funct3 (011/110/111 behave as LW)
//   data_o    - aligned, extended result
module rv32_load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rv32_mem_access_unit.sv
// MEM-stage data-memory access unit. Launches the EX/MEM load/store as a
// valid/ready request, waits for the load response (with timeout), aligns
// the read data and pulses the result towards writeback. Stalls upstream
// while the access is in flight.
// Optional feature: define RV32_MISALIGN_TRAP_EN to suppress misaligned
// half/word accesses and flag them on misalign_o instead.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   alu_res_in            - effective address
//   data_store_in         - store data (rs2)
//   data_ctrl_in          - 00 none, 01 load, 10 store, 11 none
//   code_in               - instruction (funct3 = code_in[14:12])
//   sel_rd_in             - load destination register
//   pc_hlt_in             - bubble/halt, blocks a launch
//   dmem                  - data-memory bus (master side)
//   stall_o               - freeze upstream stages
//   ld_valid_o/ld_data_o/ld_rd_o - load completion pulse and result
//   bus_err_o             - response timeout pulse
//   misalign_o            - misaligned access pulse (feature build only)
module rv32_mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            alu_res_in,
  input  logic [31:0]            data_store_in,
  input  logic [1:0]             data_ctrl_in,
  input  logic [31:0]            code_in,
  input  logic [4:0]             sel_rd_in,
  input  logic                   pc_hlt_in,
  rv32_mem_access_unit_if.master dmem,
  output logic                   stall_o,
  output logic                   ld_valid_o,
  output logic [31:0]            ld_data_o,
  output logic [4:0]             ld_rd_o,
  output logic                   bus_err_o,
  output logic                   misalign_o
);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  logic        is_store_in;
  logic        start;
  acc_size_e   size_in;
  logic        trap_in;
  logic [31:0] aligned_data;

  // Only funct3 is decoded from the instruction word.
  logic unused_code;
  assign unused_code = ^{code_in[31:15], code_in[11:0]};

  assign is_store_in = (data_ctrl_in == OP_STORE);
  assign start       = ((data_ctrl_in == OP_LOAD) || is_store_in) && !pc_hlt_in;
  assign size_in     = access_size(is_store_in, code_in[14:12]);

`ifdef RV32_MISALIGN_TRAP_EN
  assign trap_in = is_misaligned(size_in, alu_res_in[1:0]);
`else
  assign trap_in = 1'b0;
`endif

  rv32_load_align u_align (
    .rdata_i   (dmem.dmem_rsp_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .data_o    (aligned_data)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    we_d       = we_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    misalign_d = 1'b0;
    stall_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          stall_o = 1'b1;
          addr_d  = alu_res_in;
          f3_d    = code_in[14:12];
          rd_d    = sel_rd_in;
          we_d    = is_store_in;
          case (size_in)
            SZ_B:    begin be_d = 4'b0001 << alu_res_in[1:0];
                           wdata_d = {4{data_store_in[7:0]}}; end
            SZ_H:    begin be_d = alu_res_in[1] ? 4'b1100 : 4'b0011;
                           wdata_d = {2{data_store_in[15:0]}}; end
            default: begin be_d = 4'b1111; wdata_d = data_store_in; end
          endcase
          if (!is_store_in) be_d = 4'b1111;
          if (trap_in) begin
            // Misaligned: skip the bus entirely and report in DONE.
            state_d    = DONE;
            misalign_d = 1'b1;
            ld_valid_d = !is_store_in;
            ld_data_d  = 32'h0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem.dmem_req_ready) begin
          state_d = we_q ? DONE : RESP;
          cnt_d   = 8'h0;
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (dmem.dmem_rsp_valid) begin
          state_d    = DONE;
          ld_valid_d = 1'b1;
          ld_data_d  = aligned_data;
        end else if (cnt_q == 8'(RSP_TIMEOUT - 1)) begin
          // RESP has lasted RSP_TIMEOUT cycles: give up with zero data.
          state_d    = DONE;
          ld_valid_d = 1'b1;
          ld_data_d  = 32'h0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      default: begin
        // DONE: upstream still presents this instruction, so no start here.
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order. The capture
  // registers are reset too, which keeps every bus/result output at 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      f3_q       <= 3'h0;
      rd_q       <= 5'h0;
      we_q       <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'h0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  // Request valid decodes the state flop, so reset removes it immediately.
  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_req_we    = we_q;
  assign dmem.dmem_req_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_req_wdata = wdata_q;
  assign dmem.dmem_req_be    = be_q;

  assign ld_valid_o = ld_valid_q;
  assign ld_data_o  = ld_data_q;
  assign ld_rd_o    = rd_q;
  assign bus_err_o  = bus_err_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_rv32_mem_access_unit.sv
// Self-checking bench for rv32_mem_access_unit. A transaction-level model
// derives each cycle's expected outputs from the access timeline; one compare
// process checks them at every falling edge.
module tb_rv32_mem_access_unit;
  import rv32_mem_pkg::*;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_res_in = '0;
  logic [31:0] data_store_in = '0;
  logic [1:0]  data_ctrl_in = '0;
  logic [31:0] code_in = '0;
  logic [4:0]  sel_rd_in = '0;
  logic        pc_hlt_in = 1'b0;
  logic        stall_o, ld_valid_o, bus_err_o, misalign_o;
  logic [31:0] ld_data_o;
  logic [4:0]  ld_rd_o;

  rv32_mem_access_unit_if bus ();

  rv32_mem_access_unit #(.RSP_TIMEOUT(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_res_in    (alu_res_in),
    .data_store_in (data_store_in),
    .data_ctrl_in  (data_ctrl_in),
    .code_in       (code_in),
    .sel_rd_in     (sel_rd_in),
    .pc_hlt_in     (pc_hlt_in),
    .dmem          (bus),
    .stall_o       (stall_o),
    .ld_valid_o    (ld_valid_o),
    .ld_data_o     (ld_data_o),
    .ld_rd_o       (ld_rd_o),
    .bus_err_o     (bus_err_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall, req_valid, chk_req, chk_wdata, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        bus_err, misalign;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t quiet();
    exp_t e;
    e = '{stall: 1'b0, req_valid: 1'b0, chk_req: 1'b0, chk_wdata: 1'b0, we: 1'b0,
          addr: 32'h0, wdata: 32'h0, be: 4'h0, ld_valid: 1'b0, ld_data: 32'h0,
          ld_rd: 5'h0, bus_err: 1'b0, misalign: 1'b0};
    return e;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic int size_of(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit model_trap(input logic [31:0] addr, input int sz);
`ifdef RV32_MISALIGN_TRAP_EN
    return (addr % sz) != 0;
`else
    return (addr === 32'hx) && (sz == 0);
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input int sz);
    if (sz == 1) return 4'(1 << (addr % 4));
    if (sz == 2) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int sz);
    if (sz == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int sz = size_of(1'b0, f3);
    int off;
    logic [31:0] raw, mask;
    if (sz == 4) return rdata;
    off  = (sz == 1) ? int'(addr % 4) : int'((addr % 4) / 2) * 2;
    raw  = rdata >> (8 * off);
    mask = (32'h1 << (8 * sz)) - 32'h1;
    raw  = raw & mask;
    if (!f3[2] && raw[8*sz-1]) raw = raw | ~mask;
    return raw;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall_o", 32'(stall_o), 32'(e.stall));
      check("req_valid", 32'(bus.dmem_req_valid), 32'(e.req_valid));
      check("ld_valid_o", 32'(ld_valid_o), 32'(e.ld_valid));
      check("bus_err_o", 32'(bus_err_o), 32'(e.bus_err));
      check("misalign_o", 32'(misalign_o), 32'(e.misalign));
      if (e.chk_req) begin
        check("req_we", 32'(bus.dmem_req_we), 32'(e.we));
        check("req_addr", bus.dmem_req_addr, e.addr);
        check("req_be", 32'(bus.dmem_req_be), 32'(e.be));
        if (e.chk_wdata) check("req_wdata", bus.dmem_req_wdata, e.wdata);
      end
      if (e.ld_valid) begin
        check("ld_data_o", ld_data_o, e.ld_data);
        check("ld_rd_o", 32'(ld_rd_o), 32'(e.ld_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_mem();
    bus.dmem_req_ready = 1'($urandom_range(0, 1));
    bus.dmem_rsp_valid = 1'($urandom_range(0, 1));
    bus.dmem_rsp_rdata = $urandom;
  endtask

  // A cycle with no launchable instruction: none, 11, or a halted op.
  task automatic idle_cycle();
    cyc_begin();
    case ($urandom_range(0, 2))
      0: begin data_ctrl_in = 2'b00; pc_hlt_in = 1'b0; end
      1: begin data_ctrl_in = 2'b11; pc_hlt_in = 1'b0; end
      default: begin data_ctrl_in = 2'($urandom_range(1, 2)); pc_hlt_in = 1'b1; end
    endcase
    alu_res_in = $urandom;
    junk_mem();
    exp_q.push_back(quiet());
  endtask

  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input int rdy_wait, input int rsp_wait, input logic [31:0] rdata);
    exp_t e;
    logic [31:0] c;
    int  sz       = size_of(we, f3);
    bit  trap     = model_trap(addr, sz);
    bit  timeout  = !we && !trap && (rsp_wait >= T);
    int  n_resp   = (rsp_wait < T) ? rsp_wait + 1 : T;

    // Launch cycle (IDLE with start).
    cyc_begin();
    c = $urandom;
    c[14:12] = f3;
    data_ctrl_in  = we ? 2'b10 : 2'b01;
    pc_hlt_in     = 1'b0;
    alu_res_in    = addr;
    data_store_in = rs2;
    code_in       = c;
    sel_rd_in     = rd;
    junk_mem();
    e = quiet();
    e.stall = 1'b1;
    exp_q.push_back(e);

    if (!trap) begin
      for (int i = 0; i <= rdy_wait; i++) begin
        cyc_begin();
        junk_mem();
        bus.dmem_req_ready = (i == rdy_wait);
        e = quiet();
        e.stall = 1'b1; e.req_valid = 1'b1; e.chk_req = 1'b1; e.chk_wdata = we;
        e.we    = we;
        e.addr  = addr - (addr % 4);
        e.be    = we ? model_be(addr, sz) : 4'hF;
        e.wdata = model_wdata(rs2, sz);
        exp_q.push_back(e);
      end
      if (!we) begin
        for (int j = 0; j < n_resp; j++) begin
          cyc_begin();
          bus.dmem_req_ready = 1'($urandom_range(0, 1));
          bus.dmem_rsp_valid = (j == rsp_wait);
          bus.dmem_rsp_rdata = (j == rsp_wait) ? rdata : $urandom;
          e = quiet();
          e.stall = 1'b1;
          exp_q.push_back(e);
        end
      end
    end

    // DONE: upstream still holds the instruction.
    cyc_begin();
    junk_mem();
    e = quiet();
    e.ld_valid = !we;
    e.ld_rd    = rd;
    e.ld_data  = (trap || timeout) ? 32'h0 : model_load(rdata, addr, f3);
    e.bus_err  = timeout;
    e.misalign = trap;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rsp_rdata = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(bus.dmem_req_valid), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_ld_valid", 32'(ld_valid_o), 32'h0);
    check("rst_ld_data", ld_data_o, 32'h0);
    check("rst_bus_err", 32'(bus_err_o), 32'h0);
    check("rst_misalign", 32'(misalign_o), 32'h0);
    check("rst_req_addr", bus.dmem_req_addr, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model with hand-computed values.
    check("model_lb", model_load(32'h80FF_0000, 32'h203, F3_B), 32'hFFFF_FF80);
    check("model_lhu", model_load(32'h8001_1234, 32'h202, F3_HU), 32'h0000_8001);
    check("model_lh_lane0", model_load(32'h1234_F00D, 32'h101, F3_H), 32'hFFFF_F00D);
    check("model_sb_wdata", model_wdata(32'h5A, 1), 32'h5A5A_5A5A);
    check("model_sb_be", 32'(model_be(32'h101, 1)), 32'h2);
    check("model_sh_be", 32'(model_be(32'h102, 2)), 32'hC);

    idle_cycle();
    run_txn(1'b1, 32'h100, 32'hDEAD_BEEF, F3_W, 5'd3, 0, 0, 32'h0);
    idle_cycle();
    run_txn(1'b0, 32'h203, 32'h0, F3_B, 5'd7, 0, 0, 32'h80FF_0000);
    idle_cycle();
    run_txn(1'b0, 32'h202, 32'h0, F3_HU, 5'd9, 1, 1, 32'h8001_1234);
    idle_cycle();
    run_txn(1'b1, 32'h101, 32'h0000_005A, F3_B, 5'd1, 3, 0, 32'h0);
    idle_cycle();
    run_txn(1'b0, 32'h300, 32'h0, F3_W, 5'd12, 0, T, 32'h0);
    idle_cycle();
    run_txn(1'b0, 32'h101, 32'h0, F3_H, 5'd4, 0, 0, 32'h1234_F00D);
    idle_cycle();
    run_txn(1'b1, 32'h102, 32'hCAFE_1234, F3_H, 5'd0, 1, 0, 32'h0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) idle_cycle();
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
              5'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
    end
    idle_cycle();

    // Reset while a load request is pending.
    cyc_begin();
    data_ctrl_in = 2'b01; pc_hlt_in = 1'b0; alu_res_in = 32'h400;
    bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
    cyc_begin();
    data_ctrl_in = 2'b00;
    @(negedge clk);
    check("pre_rst_req_valid", 32'(bus.dmem_req_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_valid", 32'(bus.dmem_req_valid), 32'h0);
    check("async_rst_stall", 32'(stall_o), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      bus.dmem_req_ready = 1'b1;
      bus.dmem_rsp_valid = 1'b1;
      bus.dmem_rsp_rdata = $urandom;
      @(negedge clk);
      check("late_rsp_ld_valid", 32'(ld_valid_o), 32'h0);
      check("late_rsp_req_valid", 32'(bus.dmem_req_valid), 32'h0);
      check("late_rsp_stall", 32'(stall_o), 32'h0);
    end
    run_txn(1'b0, 32'h204, 32'h0, F3_W, 5'd21, 0, 0, 32'h1357_9BDF);
    idle_cycle();
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
